adder_operand_loader: RTL and testbench

Upstream feeder for the wide registered adder. Accepts a narrow valid/ready word stream carrying operand A and then operand B, least-significant word first, and assembles each into a DATA_W-bit register. It presents the completed pair on op_a/op_b, which drive the adder's inc/prop inputs, and holds the pair until the consumer accepts it. It also flags malformed frames using s_last.

---
 rtl/adder_operand_loader.sv | 123 ++++++++++++
 tb/tb_adder_operand_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_loader.sv
// Stream-to-operand loader: assembles operand A then operand B from a narrow
// valid/ready word stream (LS word first) and holds the pair for the wide adder.
module adder_operand_loader #(
    parameter int DATA_W = 1024,
    parameter int WORD_W = 32,
    parameter int NWORDS = DATA_W / WORD_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              frame_err
);

    localparam int               CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        PRESENT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic take;
    logic last_idx;
    logic bad_last_b;
    logic wr_a;
    logic wr_b;

    assign take       = s_valid && s_ready;
    assign last_idx   = (cnt == LAST_IDX);
    // In B, s_last must coincide exactly with the final word.
    assign bad_last_b = (s_last != last_idx);
    assign wr_a       = take && (state == LOAD_A);
    assign wr_b       = take && (state == LOAD_B);

    // Control: state, word counter and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= LOAD_A;
            cnt       <= '0;
            s_ready   <= 1'b0;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD_A: begin
                    s_ready <= 1'b1;
                    if (take) begin
                        if (s_last) begin
                            // Any s_last inside A is malformed; restart at word 0.
                            frame_err <= 1'b1;
                            cnt       <= '0;
                        end else if (last_idx) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    s_ready <= 1'b1;
                    if (take) begin
                        if (bad_last_b) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            state     <= LOAD_A;
                        end else if (last_idx) begin
                            cnt      <= '0;
                            state    <= PRESENT;
                            op_valid <= 1'b1;
                            s_ready  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    s_ready <= 1'b0;
                    if (op_ready) begin
                        // s_ready is still low this cycle, giving one bubble.
                        state    <= LOAD_A;
                        op_valid <= 1'b0;
                        s_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= LOAD_A;
                    cnt      <= '0;
                    s_ready  <= 1'b0;
                    op_valid <= 1'b0;
                end
            endcase
        end
    end

    // Data: word-lane writes into the operand registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_a <= '0;
            op_b <= '0;
        end else begin
            for (int k = 0; k < NWORDS; k++) begin
                if (cnt == CNT_W'(k)) begin
                    if (wr_a) op_a[k*WORD_W +: WORD_W] <= s_data;
                    if (wr_b) op_b[k*WORD_W +: WORD_W] <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader: scoreboarded frames, gaps,
// back-pressure, framing errors and mid-frame reset.
module tb_adder_operand_loader;

    localparam int DW = 1024;
    localparam int WW = 32;
    localparam int NW = DW / WW;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    logic          clk;
    logic          resetn;
    logic [WW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_valid;
    logic          op_ready;
    logic          frame_err;

    pair_t sb[$];
    int    checks = 0;
    int    passes = 0;
    int    fails  = 0;
    int    err_cnt = 0;

    adder_operand_loader #(.DATA_W(DW), .WORD_W(WW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        logic [63:0] oh, ol, eh, el;
        oh = obs[DW-1 -: 64];
        ol = obs[63:0];
        eh = exp[DW-1 -: 64];
        el = exp[63:0];
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed hi=%h lo=%h expected hi=%h lo=%h", tag, oh, ol, eh, el);
        end
    endtask

    task automatic send_word(input logic [WW-1:0] w, input logic last);
        int n;
        s_data  = w;
        s_last  = last;
        s_valid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("s_ready_timeout", {{(DW-1){1'b0}}, s_ready}, 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input int nsend, input int last_pos,
                              input int gap1, input int gap2);
        for (int i = 0; i < nsend; i++) begin
            logic [WW-1:0] w;
            w = (i < NW) ? a[i*WW +: WW] : b[(i-NW)*WW +: WW];
            send_word(w, i == last_pos);
            if (i == gap1 || i == gap2) repeat (3) tick();
        end
    endtask

    task automatic expect_present(input string tag, input int hold);
        pair_t e;
        chk({tag, "_op_valid_latency"}, op_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, sb.size(), 1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk({tag, "_op_a"}, op_a, e.a);
        chk({tag, "_op_b"}, op_b, e.b);
        chk({tag, "_s_ready_present"}, s_ready, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_valid"}, op_valid, 1);
            chk({tag, "_hold_a"}, op_a, e.a);
            chk({tag, "_hold_b"}, op_b, e.b);
            chk({tag, "_hold_s_ready"}, s_ready, 0);
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk({tag, "_op_valid_drop"}, op_valid, 0);
        chk({tag, "_s_ready_back"}, s_ready, 1);
    endtask

    initial begin
        int e0;
        logic [DW-1:0] ones;
        ones     = '1;
        resetn   = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        op_ready = 1'b0;

        // 1: reset, then A=255 B=0
        tick();
        tick();
        chk("rst_s_ready_low", s_ready, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        resetn = 1'b1;
        tick();
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_op_valid", op_valid, 0);
        chk("post_rst_op_a", op_a, 0);
        chk("post_rst_op_b", op_b, 0);
        sb.push_back('{a: 255, b: 0});
        send_frame(255, 0, 2*NW, 2*NW-1, -1, -1);
        expect_present("t1", 0);

        // 2: gaps after words 5 and 40
        e0 = err_cnt;
        sb.push_back('{a: 255, b: 1});
        send_frame(255, 1, 2*NW, 2*NW-1, 5, 40);
        expect_present("t2", 0);
        chk("t2_no_frame_err", err_cnt, e0);

        // 3: all-ones operands with 5 cycles of back-pressure
        sb.push_back('{a: ones, b: ones});
        send_frame(ones, ones, 2*NW, 2*NW-1, -1, -1);
        expect_present("t3", 5);

        // 4: early s_last on word 10, then a good frame
        e0 = err_cnt;
        send_frame(7, 9, 11, 10, -1, -1);
        chk("t4_frame_err_pulse", frame_err, 1);
        chk("t4_no_op_valid", op_valid, 0);
        tick();
        chk("t4_frame_err_one_cycle", frame_err, 0);
        chk("t4_no_op_valid_after", op_valid, 0);
        chk("t4_err_count", err_cnt, e0 + 1);
        sb.push_back('{a: 3, b: 4});
        send_frame(3, 4, 2*NW, 2*NW-1, -1, -1);
        expect_present("t4", 0);

        // 5: missing s_last on the final word
        e0 = err_cnt;
        send_frame(5, 6, 2*NW, -1, -1, -1);
        chk("t5_frame_err_pulse", frame_err, 1);
        chk("t5_no_op_valid", op_valid, 0);
        tick();
        chk("t5_frame_err_one_cycle", frame_err, 0);
        chk("t5_no_op_valid_after", op_valid, 0);
        chk("t5_err_count", err_cnt, e0 + 1);

        // 6: reset after word 20 of A
        e0 = err_cnt;
        send_frame(ones, ones, 21, -1, -1, -1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t6_op_a_cleared", op_a, 0);
        chk("t6_op_b_cleared", op_b, 0);
        chk("t6_op_valid", op_valid, 0);
        chk("t6_frame_err", frame_err, 0);
        chk("t6_s_ready_in_reset", s_ready, 0);
        tick();
        chk("t6_s_ready_after", s_ready, 1);
        chk("t6_no_err_count", err_cnt, e0);
        sb.push_back('{a: 255, b: 1});
        send_frame(255, 1, 2*NW, 2*NW-1, -1, -1);
        expect_present("t6", 0);

        chk("sb_drained", sb.size(), 0);
        chk("total_err_count", err_cnt, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
